digit_serial_adder: RTL
=======================

Name: digit_serial_adder

Overview:
- Parametrised, multi-cycle successor to the team's small combinational ripple adders.
- Adds two WIDTH-bit operands presented DIGIT bits per cycle, least significant digit first, using a registered carry between digits.
- Emits each sum digit, assembles the full sum, and reports final carry and signed overflow.
- Sits behind the chip's narrow 8-bit I/O, so wide operands stream through few pins.

Parameters:
- WIDTH, 12, total operand/sum width in bits; must be an integer multiple of DIGIT.
- DIGIT, 3, bits accepted and produced per transfer; 1..WIDTH.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins an operation.
- cin  input  1  carry-in; sampled on the start cycle.
- in_valid  input  1  a_digit/b_digit hold a digit this cycle.
- a_digit  input  DIGIT  operand A digit, LSD first.
- b_digit  input  DIGIT  operand B digit, LSD first.
- busy  output  1  high in RUN.
- sum_valid  output  1  sum_digit valid this cycle.
- sum_digit  output  DIGIT  registered sum digit.
- sum  output  WIDTH  assembled result.
- carry_out  output  1  final carry out of the MSB.
- overflow  output  1  two's-complement overflow of the final result.
- done  output  1  one-cycle pulse when the result is complete.

Behaviour:
- Derived constant NUM_DIGITS = WIDTH/DIGIT. Digit counter is clog2(NUM_DIGITS) bits wide, minimum 1.
- Reset values: every output is 0; state is IDLE; carry register, counter and sum register are 0.
- States:
  - IDLE: on start, latch cin into the carry register, clear the counter, clear sum, assert busy next cycle, and go to RUN. in_valid is ignored in IDLE and on the start cycle itself.
  - RUN: each in_valid cycle accepts one digit and computes {c,s} = a_digit + b_digit + carry.
    - s is registered into sum_digit with sum_valid = 1 the next cycle, and written into sum bits [k*DIGIT +: DIGIT] for digit k.
    - c is written to the carry register and the counter increments.
    - in_valid = 0 stalls: carry, counter and sum are held, and sum_valid = 0.
  - On acceptance of digit NUM_DIGITS-1, go to IDLE. In the following cycle done = 1 together with the final sum_valid, and busy = 0.
- Final outputs:
  - carry_out = c of the last digit.
  - overflow = carry into the MSB XOR carry out of the MSB, computed within the last digit.
  - sum, carry_out and overflow hold until the next start, which clears them.
- Latency:
  - Each sum digit appears 1 cycle after its digit is accepted.
  - Minimum operation time is 1 (start) + NUM_DIGITS + 1 cycles.
- Boundary rules:
  - start while in RUN is ignored.
  - start in the cycle done is high is accepted; done still pulses.
  - Reset mid-operation aborts immediately to IDLE; no done pulse; all outputs return to 0.
  - Sum wraps modulo 2^WIDTH.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled on the start cycle.
  - When sub = 1, b_digit is inverted before the add and the carry register is loaded with 1, ignoring cin. Result is A − B.
  - carry_out = 1 means no borrow.
  - overflow uses the same XOR rule.
- When undefined: no sub port, and the block always adds.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN};
  - a function computing NUM_DIGITS and the counter width;
  - the default WIDTH/DIGIT constants.
- One natural sub-module: digit_add_cell. It is a purely combinational DIGIT-bit adder with carry-in, exposing the carry-out and the carry into its MSB (for overflow). It is instantiated once.

Test Plan:
- Basic add, WIDTH=12, DIGIT=3, cin=0: A=0x5A7 (digits 7,4,6,2), B=0x3C9 (digits 1,1,7,1) streamed back-to-back → sum_digit 0,6,5,4; sum=0x970; carry_out=0; overflow=1; done pulses once.
- Wrap: A=0xFFF, B=0x001 → sum=0x000, carry_out=1, overflow=0.
- Stall and cin: A=0x000, B=0x000, cin=1, in_valid low for 3 cycles between digits 1 and 2 → sum=0x001, no sum_valid during stall, done after the 4th accepted digit.
- Reset and ignored start: reset asserted after 2 digits → all outputs 0, no done; a fresh op 0x123+0x321 then yields 0x444. A start pulse issued mid-RUN is ignored.
- Subtract (DIGIT_SERIAL_ADDER_SUB_EN defined, sub=1): 0x100−0x001 → sum=0x0FF, carry_out=1. 0x000−0x001 → sum=0xFFF, carry_out=0.

Source files
------------

// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: state encoding, default sizing
// and helpers that derive the digit count and digit-counter width.
package digit_serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 12;
  localparam int DEFAULT_DIGIT = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a one-bit counter.
  function automatic int counter_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_cell.sv
// Combinational DIGIT-bit ripple adder with carry-in; also exposes the carry
// into its MSB so the caller can form the two's-complement overflow flag.
module digit_add_cell #(
  parameter int DIGIT = 3
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: streams WIDTH-bit operands DIGIT bits per cycle, LSD first,
// with a registered inter-digit carry. Optional subtract mode: DIGIT_SERIAL_ADDER_SUB_EN.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  input  logic [DIGIT-1:0] a_digit,
  input  logic [DIGIT-1:0] b_digit,
  output logic             busy,
  output logic             sum_valid,
  output logic [DIGIT-1:0] sum_digit,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             done
);

  localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int CW         = counter_width(NUM_DIGITS);

  state_t           state, state_next;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic [DIGIT-1:0] sum_digit_q;
  logic             sum_valid_q;
  logic             done_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic             accept;
  logic             last;
  logic             carry_init;
  logic [DIGIT-1:0] b_eff;
  logic [DIGIT-1:0] cell_s;
  logic             cell_cout;
  logic             cell_c_msb;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  logic sub_q;

  // Subtraction is A + ~B + 1, so the initial carry is forced high.
  assign carry_init = sub ? 1'b1 : cin;
  assign b_eff      = b_digit ^ {DIGIT{sub_q}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      sub_q <= 1'b0;
    else if (state == IDLE && start)
      sub_q <= sub;
  end
`else
  assign carry_init = cin;
  assign b_eff      = b_digit;
`endif

  assign accept = (state == RUN) && in_valid;
  assign last   = (cnt_q == CW'(NUM_DIGITS - 1));

  digit_add_cell #(
    .DIGIT(DIGIT)
  ) u_cell (
    .a    (a_digit),
    .b    (b_eff),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout),
    .c_msb(cell_c_msb)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (in_valid && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sum_digit_q <= '0;
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (state == IDLE && start) begin
        carry_q     <= carry_init;
        cnt_q       <= '0;
        sum_q       <= '0;
        carry_out_q <= 1'b0;
        overflow_q  <= 1'b0;
      end else if (accept) begin
        carry_q     <= cell_cout;
        cnt_q       <= cnt_q + CW'(1);
        sum_digit_q <= cell_s;
        sum_valid_q <= 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (cnt_q == CW'(k))
            sum_q[k*DIGIT +: DIGIT] <= cell_s;
        end
        if (last) begin
          done_q      <= 1'b1;
          carry_out_q <= cell_cout;
          overflow_q  <= cell_c_msb ^ cell_cout;
        end
      end
    end
  end

  assign busy      = (state == RUN);
  assign sum_valid = sum_valid_q;
  assign sum_digit = sum_digit_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign done      = done_q;

endmodule
